// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: ID/EX to EX multiply/divide bundle.
// master = pipeline side, slave = ex_muldiv.
interface ex_muldiv_if;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_rs1;
  logic [31:0] md_rs2;
  logic [4:0]  md_rd_addr;
  logic        flush;
  logic        stallreq_ex;
  logic        md_done;
  logic [31:0] md_result;
  logic [4:0]  md_rd_addr_o;
  logic        md_rd_enable;

  modport master (
    output md_start, md_op, md_rs1, md_rs2,
    output md_rd_addr, flush,
    input  stallreq_ex, md_done, md_result,
    input  md_rd_addr_o, md_rd_enable
  );

  modport slave (
    input  md_start, md_op, md_rs1, md_rs2,
    input  md_rd_addr, flush,
    output stallreq_ex, md_done, md_result,
    output md_rd_addr_o, md_rd_enable
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M mul/div, 32 steps per op.
// MULDIV_EARLY_OUT_EN: special cases finish one cycle after start.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input logic      clk,
  input logic      rst,
  ex_muldiv_if.slave md
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [5:0]  r_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_result;
  logic        r_neg;
  logic [4:0]  r_rd;

  logic        w_div;
  logic        w_sgn1;
  logic        w_sgn2;
  logic        w_neg1;
  logic        w_neg2;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic        w_bz;
  logic        w_neg_res;
  logic        w_start;
  logic        w_early;
  logic [31:0] w_early_res;

  assign w_div  = md.md_op[2];
  assign w_sgn1 = w_div ? !md.md_op[0]
                        : (md.md_op[1:0] != 2'b11);
  assign w_sgn2 = w_div ? !md.md_op[0] : !md.md_op[1];
  assign w_neg1 = md.md_rs1[31] & w_sgn1;
  assign w_neg2 = md.md_rs2[31] & w_sgn2;
  assign w_mag1 = w_neg1 ? -md.md_rs1 : md.md_rs1;
  assign w_mag2 = w_neg2 ? -md.md_rs2 : md.md_rs2;
  assign w_bz   = (md.md_rs2 == 32'd0);

  // Divide-by-zero quotient stays all-ones: never negate it.
  assign w_neg_res = !w_div ? (w_neg1 ^ w_neg2)
                   : md.md_op[1] ? w_neg1
                   : (w_neg1 ^ w_neg2) & !w_bz;

  assign w_start = (r_state == S_IDLE) &&
                   md.md_start && !md.flush;

`ifdef MULDIV_EARLY_OUT_EN
  logic w_ovf;
  logic w_mz;
  assign w_ovf = w_div && !md.md_op[0] &&
                 (md.md_rs1 == 32'h8000_0000) &&
                 (md.md_rs2 == 32'hFFFF_FFFF);
  assign w_mz  = !w_div && ((md.md_rs1 == 32'd0) || w_bz);
  assign w_early = (w_div && w_bz) || w_ovf || w_mz;
  always_comb begin
    w_early_res = 32'd0;
    if (w_div && w_bz)
      w_early_res = md.md_op[1] ? md.md_rs1 : 32'hFFFF_FFFF;
    else if (w_ovf)
      w_early_res = md.md_op[1] ? 32'd0 : 32'h8000_0000;
  end
`else
  assign w_early     = 1'b0;
  assign w_early_res = 32'd0;
`endif

  logic [32:0] w_msum;
  logic [32:0] w_rsh;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [31:0] w_hi_nx;
  logic [31:0] w_lo_nx;

  // Mul: hi accumulates, lo shifts out multiplier bits.
  // Div: hi is partial remainder, lo shifts dividend->quotient.
  assign w_msum  = {1'b0, r_hi} +
                   {1'b0, (r_lo[0] ? r_b : 32'd0)};
  assign w_rsh   = {r_hi, r_lo[31]};
  assign w_ge    = (w_rsh >= {1'b0, r_b});
  assign w_sub   = w_rsh[31:0] - r_b;
  assign w_hi_nx = r_op[2] ? (w_ge ? w_sub : w_rsh[31:0])
                           : w_msum[32:1];
  assign w_lo_nx = r_op[2] ? {r_lo[30:0], w_ge}
                           : {w_msum[0], r_lo[31:1]};

  logic [63:0] w_prod;
  logic [63:0] w_prod_s;
  logic [31:0] w_qr;
  logic [31:0] w_qr_s;
  logic [31:0] w_final;

  assign w_prod   = {w_hi_nx, w_lo_nx};
  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_qr     = r_op[1] ? w_hi_nx : w_lo_nx;
  assign w_qr_s   = r_neg ? -w_qr : w_qr;
  assign w_final  = r_op[2] ? w_qr_s
                  : (r_op[1:0] == 2'b00) ? w_prod_s[31:0]
                  : w_prod_s[63:32];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_start)
          w_state_nx = w_early ? S_DONE : S_BUSY;
      S_BUSY:
        if (md.flush)              w_state_nx = S_IDLE;
        else if (r_cnt == 6'd31)   w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 6'd0;
      r_op     <= 3'd0;
      r_b      <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_result <= 32'd0;
      r_neg    <= 1'b0;
      r_rd     <= 5'd0;
    end else if (w_start) begin
      r_cnt <= 6'd0;
      r_op  <= md.md_op;
      r_neg <= w_neg_res;
      r_rd  <= md.md_rd_addr;
      r_hi  <= 32'd0;
      r_b   <= w_div ? w_mag2 : w_mag1;
      r_lo  <= w_div ? w_mag1 : w_mag2;
      if (w_early) r_result <= w_early_res;
    end else if (r_state == S_BUSY && !md.flush) begin
      r_hi  <= w_hi_nx;
      r_lo  <= w_lo_nx;
      r_cnt <= r_cnt + 6'd1;
      if (r_cnt == 6'd31) r_result <= w_final;
    end
  end

  assign md.stallreq_ex  = w_start || (r_state == S_BUSY);
  assign md.md_done      = (r_state == S_DONE) && !md.flush;
  assign md.md_result    = r_result;
  assign md.md_rd_addr_o = r_rd;
  assign md.md_rd_enable = md.md_done && (r_rd != 5'd0);

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vector table plus flush/reset sequences.
// Expected latency depends on MULDIV_EARLY_OUT_EN.
module tb_ex_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_muldiv_if bus ();

  ex_muldiv dut (
    .clk (clk),
    .rst (rst),
    .md  (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          sp;
  } vec_t;

  vec_t tbl[18];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int lat_of(input bit sp);
`ifdef MULDIV_EARLY_OUT_EN
    return sp ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  // Entered #1 after a posedge with the unit idle.
  task automatic run(input logic [2:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [4:0] rd,
                     input logic [31:0] exp,
                     input int lat);
    int cyc;
    bit got;
    bit stall_ok;
    bus.md_op      = op;
    bus.md_rs1     = a;
    bus.md_rs2     = b;
    bus.md_rd_addr = rd;
    bus.md_start   = 1'b1;
    #1;
    chk("stall_at_start", {31'd0, bus.stallreq_ex}, 32'd1);
    cyc = 0;
    got = 0;
    stall_ok = 1;
    while (!got && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.md_done) got = 1;
      else if (!bus.stallreq_ex) stall_ok = 0;
    end
    chk("stall_while_busy", {31'd0, stall_ok}, 32'd1);
    chk("done_latency", cyc, lat);
    if (got) begin
      chk("result", bus.md_result, exp);
      chk("rd_addr", {27'd0, bus.md_rd_addr_o}, {27'd0, rd});
      chk("rd_enable", {31'd0, bus.md_rd_enable},
          {31'd0, rd != 5'd0});
      chk("stall_in_done", {31'd0, bus.stallreq_ex}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.md_start = 1'b0;
    #1;
    chk("no_second_done", {31'd0, bus.md_done}, 32'd0);
  endtask

  initial begin
    tbl[0]  = '{3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    tbl[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    tbl[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0};
    tbl[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,        1'b0};
    tbl[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,         1'b0};
    tbl[8]  = '{3'd4, 32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1};
    tbl[9]  = '{3'd6, 32'd5,        32'd0,        32'd5,         1'b1};
    tbl[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    tbl[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1'b1};
    tbl[12] = '{3'd4, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFFF, 1'b1};
    tbl[13] = '{3'd6, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 1'b1};
    tbl[14] = '{3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1};
    tbl[15] = '{3'd0, 32'd0,        32'd5,        32'd0,         1'b1};
    tbl[16] = '{3'd3, 32'h1234_5678, 32'd0,        32'd0,         1'b1};
    tbl[17] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};

    bus.md_start   = 1'b0;
    bus.md_op      = 3'd0;
    bus.md_rs1     = 32'd0;
    bus.md_rs2     = 32'd0;
    bus.md_rd_addr = 5'd0;
    bus.flush      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", {31'd0, bus.md_done}, 32'd0);
    chk("rst_result", bus.md_result, 32'd0);
    chk("rst_rd", {27'd0, bus.md_rd_addr_o}, 32'd0);
    chk("rst_rd_en", {31'd0, bus.md_rd_enable}, 32'd0);
    chk("rst_stall", {31'd0, bus.stallreq_ex}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++)
      run(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i),
          tbl[i].exp, lat_of(tbl[i].sp));

    // Flush in BUSY cycle N+10.
    bus.md_op    = 3'd0;
    bus.md_rs1   = 32'd7;
    bus.md_rs2   = 32'd9;
    bus.md_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
    end
    chk("flush_busy_stall", {31'd0, bus.stallreq_ex}, 32'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.md_start = 1'b0;
    #1;
    chk("flush_stall_drop", {31'd0, bus.stallreq_ex}, 32'd0);
    begin
      bit seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk);
        #1;
        if (bus.md_done || bus.stallreq_ex) seen = 1;
      end
      chk("flush_no_done", {31'd0, seen}, 32'd0);
    end
    run(3'd0, 32'd3, 32'd4, 5'd9, 32'd12, 33);

    // Reset in BUSY cycle N+5.
    bus.md_op      = 3'd5;
    bus.md_rs1     = 32'd1000;
    bus.md_rs2     = 32'd3;
    bus.md_rd_addr = 5'd17;
    bus.md_start   = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
    end
    rst          = 1'b1;
    bus.md_start = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_done", {31'd0, bus.md_done}, 32'd0);
    chk("mid_rst_result", bus.md_result, 32'd0);
    chk("mid_rst_rd", {27'd0, bus.md_rd_addr_o}, 32'd0);
    chk("mid_rst_rd_en", {31'd0, bus.md_rd_enable}, 32'd0);
    chk("mid_rst_stall", {31'd0, bus.stallreq_ex}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run(3'd5, 32'd100, 32'd7, 5'd3, 32'd14, 33);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_bad);
    $finish;
  end

endmodule
